// File: rtl/srx_deser_if.sv
// Valid/ready word stream carrying recovered words from srx_deser to its consumer.
interface srx_deser_if #(
   parameter int DW = 16
);
   logic [DW-1:0] o_rx_data;
   logic          o_rx_vld;
   logic          i_rx_rdy;

   modport master (output o_rx_data, output o_rx_vld, input i_rx_rdy);
   modport slave  (input o_rx_data, input o_rx_vld, output i_rx_rdy);
endinterface

// File: rtl/srx_deser.sv
// Frame-sync serial receiver: rebuilds DW-bit words from an MSB-first bit stream
// and queues them in a small show-ahead FIFO with overflow and framing-error reporting.
module srx_deser #(
   parameter int DW      = 16,
   parameter int FIFO_AW = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_fs,
   input  logic        i_d,
   srx_deser_if.master rx,
   output logic        o_ovf,
   input  logic        i_ovf_clr,
   output logic        o_frame_err,
   output logic [15:0] o_word_cnt,
   output logic [7:0]  o_err_cnt
);

   localparam int CNT_W = $clog2(DW);
   localparam int DEPTH = 1 << FIFO_AW;

   typedef enum logic {S_IDLE, S_RECV} state_e;

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
   logic [DW-1:0]        shreg_q, shreg_d;
   logic                 frame_err_q, frame_err_d;
   logic                 ovf_q, ovf_d;
   logic [15:0]          word_cnt_q, word_cnt_d;
   logic [7:0]           err_cnt_q, err_cnt_d;
   logic [FIFO_AW:0]     wr_ptr_q, wr_ptr_d;
   logic [FIFO_AW:0]     rd_ptr_q, rd_ptr_d;
   logic [DW-1:0]        rx_data_q, rx_data_d;
   logic                 rx_vld_q, rx_vld_d;
   logic [DW-1:0]        mem_q [DEPTH];

   logic                 push, pop, push_ok, drop, fifo_full;
   logic [DW-1:0]        push_word;

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shreg_d     = shreg_q;
      frame_err_d = 1'b0;
      push        = 1'b0;
      push_word   = {shreg_q[DW-2:0], i_d};
      unique case (state_q)
         S_IDLE: begin
            if (i_fs) begin
               shreg_d   = push_word;
               bit_cnt_d = CNT_W'(1);
               state_d   = S_RECV;
            end
         end
         S_RECV: begin
            if (i_fs) begin
               // Sync inside a frame: drop the partial word and treat this bit as a new MSB.
               frame_err_d = 1'b1;
               shreg_d     = push_word;
               bit_cnt_d   = CNT_W'(1);
            end else if (bit_cnt_q == CNT_W'(DW - 1)) begin
               push      = 1'b1;
               bit_cnt_d = '0;
               state_d   = S_IDLE;
            end else begin
               shreg_d   = push_word;
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      fifo_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                   (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
      pop        = rx.i_rx_rdy & rx_vld_q;
      push_ok    = push & (~fifo_full | pop);
      drop       = push & fifo_full & ~pop;
      wr_ptr_d   = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      rx_vld_d   = (wr_ptr_d != rd_ptr_d);
      // Next head is the incoming word only when it lands in the slot the read pointer moves to.
      rx_data_d  = rx_data_q;
      if (rx_vld_d) begin
         if (push_ok && (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_d[FIFO_AW-1:0]))
            rx_data_d = push_word;
         else
            rx_data_d = mem_q[rd_ptr_d[FIFO_AW-1:0]];
      end
      ovf_d      = drop | (ovf_q & ~i_ovf_clr);
      word_cnt_d = word_cnt_q + 16'(push_ok);
      err_cnt_d  = (frame_err_d && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         bit_cnt_q   <= '0;
         shreg_q     <= '0;
         frame_err_q <= 1'b0;
         ovf_q       <= 1'b0;
         word_cnt_q  <= '0;
         err_cnt_q   <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         rx_data_q   <= '0;
         rx_vld_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shreg_q     <= shreg_d;
         frame_err_q <= frame_err_d;
         ovf_q       <= ovf_d;
         word_cnt_q  <= word_cnt_d;
         err_cnt_q   <= err_cnt_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         rx_data_q   <= rx_data_d;
         rx_vld_q    <= rx_vld_d;
      end
   end

   // NOTE: storage is not reset; the pointers alone decide which entries are live.
   always_ff @(posedge clk) begin
      if (push_ok)
         mem_q[wr_ptr_q[FIFO_AW-1:0]] <= push_word;
   end

   assign rx.o_rx_data = rx_data_q;
   assign rx.o_rx_vld  = rx_vld_q;
   assign o_ovf        = ovf_q;
   assign o_frame_err  = frame_err_q;
   assign o_word_cnt   = word_cnt_q;
   assign o_err_cnt    = err_cnt_q;

endmodule
